// File: rtl/ws2812_stream_decoder.sv
// WS2812B receive-side decoder: measures each high pulse on the synchronised line,
// packs bits LSB-first into 24-bit words and detects the long-low latch code.
module ws2812_stream_decoder #(
    parameter int MIN_HIGH   = 6,
    parameter int BIT_THRESH = 24,
    parameter int MAX_HIGH   = 60,
    parameter int RESET_LOW  = 1000,
    parameter int CNT_W      = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] data,
    output logic        valid,
    output logic        latch,
    output logic [8:0]  frame_words,
    output logic        err
);

    typedef enum logic [1:0] {
        WAIT_RST,
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] MIN_HIGH_C   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] BIT_THRESH_C = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MAX_HIGH_C   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_LOW_C  = CNT_W'(RESET_LOW);

    state_t            state_reg, state_next;
    logic              din_meta_reg, din_s_reg, din_q_reg;
    logic              rise, fall;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    logic [4:0]        bitidx_reg, bitidx_next;
    logic [23:0]       shreg_reg, shreg_next;
    logic [8:0]        word_cnt_reg, word_cnt_next, word_cnt_inc;
    logic [23:0]       data_next;
    logic [8:0]        frame_words_next;
    logic              valid_next, latch_next, err_next;
    logic              bit_val, shift_en;

    assign rise    = din_s_reg & ~din_q_reg;
    assign fall    = ~din_s_reg & din_q_reg;
    assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign word_cnt_inc = (word_cnt_reg == '1) ? word_cnt_reg : word_cnt_reg + 9'd1;
    assign bit_val = (cnt_reg >= BIT_THRESH_C);

    // Each shift-register bit only loads when its own index is the one being decoded.
    genvar gi;
    generate
        for (gi = 0; gi < 24; gi++) begin : g_shreg
            assign shreg_next[gi] = (shift_en && (bitidx_reg == 5'(gi))) ? bit_val : shreg_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_inc;
        bitidx_next      = bitidx_reg;
        word_cnt_next    = word_cnt_reg;
        data_next        = data;
        frame_words_next = frame_words;
        valid_next       = 1'b0;
        latch_next       = 1'b0;
        err_next         = 1'b0;
        shift_en         = 1'b0;

        case (state_reg)
            WAIT_RST: begin
                if (din_s_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == RESET_LOW_C) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                    cnt_next   = CNT_W'(1);
                end
            end
            HIGH: begin
                if (din_s_reg) begin
                    if (cnt_reg == MAX_HIGH_C) begin
                        err_next      = 1'b1;
                        state_next    = WAIT_RST;
                        cnt_next      = '0;
                        bitidx_next   = '0;
                        word_cnt_next = '0;
                    end
                end else if (fall) begin
                    if (cnt_reg < MIN_HIGH_C) begin
                        err_next      = 1'b1;
                        state_next    = WAIT_RST;
                        cnt_next      = '0;
                        bitidx_next   = '0;
                        word_cnt_next = '0;
                    end else begin
                        shift_en   = 1'b1;
                        state_next = LOW;
                        cnt_next   = CNT_W'(1);
                        if (bitidx_reg == 5'd23) begin
                            data_next     = {bit_val, shreg_reg[22:0]};
                            valid_next    = 1'b1;
                            bitidx_next   = '0;
                            word_cnt_next = word_cnt_inc;
                        end else begin
                            bitidx_next = bitidx_reg + 5'd1;
                        end
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_next = HIGH;
                    cnt_next   = CNT_W'(1);
                end else if (cnt_reg == RESET_LOW_C) begin
                    latch_next       = 1'b1;
                    frame_words_next = word_cnt_reg;
                    word_cnt_next    = '0;
                    state_next       = IDLE;
                    // A latch arriving mid-word means the partial word is lost.
                    if (bitidx_reg != 5'd0) begin
                        err_next    = 1'b1;
                        bitidx_next = '0;
                    end
                end
            end
            default: begin
                state_next = WAIT_RST;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_meta_reg <= 1'b0;
            din_s_reg    <= 1'b0;
            din_q_reg    <= 1'b0;
            state_reg    <= WAIT_RST;
            cnt_reg      <= '0;
            bitidx_reg   <= '0;
            shreg_reg    <= '0;
            word_cnt_reg <= '0;
            data         <= '0;
            frame_words  <= '0;
            valid        <= 1'b0;
            latch        <= 1'b0;
            err          <= 1'b0;
        end else begin
            din_meta_reg <= din;
            din_s_reg    <= din_meta_reg;
            din_q_reg    <= din_s_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bitidx_reg   <= bitidx_next;
            shreg_reg    <= shreg_next;
            word_cnt_reg <= word_cnt_next;
            data         <= data_next;
            frame_words  <= frame_words_next;
            valid        <= valid_next;
            latch        <= latch_next;
            err          <= err_next;
        end
    end

endmodule

// File: tb/tb_ws2812_stream_decoder.sv
// Scoreboard bench for ws2812_stream_decoder: directed pulse streams push expected
// output events; a negedge monitor pops and compares each valid/latch/err cycle.
module tb_ws2812_stream_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] data;
    logic        valid;
    logic        latch;
    logic [8:0]  frame_words;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  mask;   // {err, latch, valid}
        logic [23:0] data;
        logic [8:0]  fw;
    } ev_t;

    ev_t sb[$];

    ws2812_stream_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .data        (data),
        .valid       (valid),
        .latch       (latch),
        .frame_words (frame_words),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input logic [2:0] m, input logic [23:0] d, input logic [8:0] f);
        ev_t e;
        e.mask = m;
        e.data = d;
        e.fw   = f;
        sb.push_back(e);
    endtask

    task automatic hold(input int n, input logic v);
        repeat (n) begin
            @(negedge clk);
            din = v;
        end
    endtask

    task automatic send_bit(input logic b);
        hold(b ? 32 : 16, 1'b1);
        hold(b ? 18 : 34, 1'b0);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data", {8'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_latch", {31'd0, latch}, 32'd0);
        check("rst_fw", {23'd0, frame_words}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
    endtask

    // Monitor: every cycle with any event output high is one transaction.
    ev_t        mon_e;
    logic [2:0] mon_m;
    always @(negedge clk) begin
        if (valid || latch || err) begin
            mon_m = {err, latch, valid};
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event mask=%b data=%h fw=%0d required=none", mon_m, data, frame_words);
            end else begin
                mon_e = sb.pop_front();
                if (mon_m !== mon_e.mask ||
                    (mon_m[0] && data !== mon_e.data) ||
                    (mon_m[1] && frame_words !== mon_e.fw)) begin
                    n_err++;
                    $display("FAIL event actual mask=%b data=%h fw=%0d required mask=%b data=%h fw=%0d",
                             mon_m, data, frame_words, mon_e.mask, mon_e.data, mon_e.fw);
                end else begin
                    $display("event mask=%b data=%h fw=%0d ok", mon_m, data, frame_words);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // 1: single word after arming, then latch
        hold(1010, 1'b0);
        expect_ev(3'b001, 24'h00B000, 9'd0);
        expect_ev(3'b010, 24'h0, 9'd1);
        send_bits(24'h00B000, 24);
        hold(2000, 1'b0);

        // 2: three words back to back
        expect_ev(3'b001, 24'h00F060, 9'd0);
        expect_ev(3'b001, 24'h0000B0, 9'd0);
        expect_ev(3'b001, 24'hB05000, 9'd0);
        expect_ev(3'b010, 24'h0, 9'd3);
        send_bits(24'h00F060, 24);
        send_bits(24'h0000B0, 24);
        send_bits(24'hB05000, 24);
        hold(2000, 1'b0);

        // 3: glitch, ignored word, re-arm, good word
        expect_ev(3'b100, 24'h0, 9'd0);
        hold(3, 1'b1);
        hold(20, 1'b0);
        send_bits(24'h123456, 24);
        hold(1010, 1'b0);
        expect_ev(3'b001, 24'h0000B0, 9'd0);
        expect_ev(3'b010, 24'h0, 9'd1);
        send_bits(24'h0000B0, 24);
        hold(2000, 1'b0);

        // 4: stuck high, early word ignored, re-arm after full low
        expect_ev(3'b100, 24'h0, 9'd0);
        hold(100, 1'b1);
        hold(500, 1'b0);
        send_bits(24'hABCDEF, 24);
        hold(1010, 1'b0);
        expect_ev(3'b001, 24'h00F060, 9'd0);
        expect_ev(3'b010, 24'h0, 9'd1);
        send_bits(24'h00F060, 24);
        hold(2000, 1'b0);

        // 5: partial word then latch -> latch and err together
        expect_ev(3'b110, 24'h0, 9'd0);
        send_bits(24'h00B000, 10);
        hold(2000, 1'b0);

        // 6: reset mid-word, then unarmed word gives nothing
        send_bits(24'h00B000, 12);
        hold(8, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        din = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        send_bits(24'h00F060, 24);
        hold(2000, 1'b0);
        expect_ev(3'b001, 24'hB05000, 9'd0);
        expect_ev(3'b010, 24'h0, 9'd1);
        send_bits(24'hB05000, 24);
        hold(2000, 1'b0);

        hold(50, 1'b0);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
